// File: rtl/alu_ctrl_mc_pkg.sv
// rtl/alu_ctrl_mc_pkg.sv - ALU control encodings and multiply sequencer states
package alu_ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LUI   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b111;
  localparam logic [2:0] OP_BGEZ  = 3'b101;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_MUL  = 4'b0011;
  localparam logic [3:0] C_LUI  = 4'b0100;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MFHI = 4'b1000;
  localparam logic [3:0] C_MFLO = 4'b1001;
  localparam logic [3:0] C_SRLV = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_ctrl_mc_if.sv
// rtl/alu_ctrl_mc_if.sv - execute-stage bus between pipeline and ALU controller
interface alu_ctrl_mc_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUOp_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ALUCtrl_o;
  logic             illegal_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output valid_i, ALUOp_i, funct_i, src1_i, src2_i,
    input  ALUCtrl_o, illegal_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i, src1_i, src2_i,
    output ALUCtrl_o, illegal_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/alu_ctrl_mc_mul_seq.sv
// rtl/alu_ctrl_mc_mul_seq.sv - iterative shift-add multiplier owning HI/LO
module mul_seq
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             idle_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, acc_q, mplr_q, hi_q, lo_q;
  logic             neg_q, done_q;

  logic [WIDTH-1:0]   mag1_d, mag2_d;
  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] prod_d;

  // Magnitudes fit W unsigned bits, including the most-negative operand.
  always_comb begin
    mag1_d = (signed_i && src1_i[WIDTH-1]) ? (~src1_i + 1'b1) : src1_i;
    mag2_d = (signed_i && src2_i[WIDTH-1]) ? (~src2_i + 1'b1) : src2_i;
    sum_d  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = neg_q ? (~{acc_q, mplr_q} + 1'b1) : {acc_q, mplr_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          mcand_q <= mag1_d;
          mplr_q  <= mag2_d;
          acc_q   <= '0;
          neg_q   <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
          cnt_q   <= CNT_W'(WIDTH);
          state_q <= S_RUN;
        end
        S_RUN: begin
          {acc_q, mplr_q} <= {sum_d, mplr_q[WIDTH-1:1]};
          cnt_q           <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          {hi_q, lo_q} <= prod_d;
          done_q       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign idle_o = (state_q == S_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - ALU control decode with multi-cycle mult/multu and stall
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_ctrl_mc_if.slave bus
);
  logic [3:0] ctrl_d;
  logic       known_d, is_mul_d, start_d, idle_d;

  always_comb begin
    ctrl_d  = C_AND;
    known_d = 1'b1;
    case (bus.ALUOp_i)
      OP_RTYPE: begin
        case (bus.funct_i)
          F_ADD:   ctrl_d = C_ADD;
          F_SUB:   ctrl_d = C_SUB;
          F_AND:   ctrl_d = C_AND;
          F_OR:    ctrl_d = C_OR;
          F_SLT:   ctrl_d = C_SLT;
          F_SLL:   ctrl_d = C_SLL;
          F_SRLV:  ctrl_d = C_SRLV;
          F_MULT:  ctrl_d = C_MUL;
          F_MULTU: ctrl_d = C_MUL;
          F_MFHI:  ctrl_d = C_MFHI;
          F_MFLO:  ctrl_d = C_MFLO;
          default: known_d = 1'b0;
        endcase
      end
      OP_ADD:  ctrl_d = C_ADD;
      OP_SLT:  ctrl_d = C_SLT;
      OP_SUB:  ctrl_d = C_SUB;
      OP_LUI:  ctrl_d = C_LUI;
      OP_OR:   ctrl_d = C_OR;
      OP_BGEZ: ctrl_d = C_MUL;
      default: known_d = 1'b0;
    endcase
  end

  // bgez shares code 0011 with mult but must never launch the sequencer.
  assign is_mul_d = (bus.ALUOp_i == OP_RTYPE) &&
                    ((bus.funct_i == F_MULT) || (bus.funct_i == F_MULTU));
  assign start_d  = bus.valid_i & is_mul_d & idle_d;

  assign bus.ALUCtrl_o = ctrl_d;
  assign bus.illegal_o = bus.valid_i & ~known_d;
  assign bus.busy_o    = start_d | ~idle_d;

  mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_d),
    .signed_i (bus.funct_i == F_MULT),
    .src1_i   (bus.src1_i),
    .src2_i   (bus.src2_i),
    .idle_o   (idle_d),
    .done_o   (bus.done_o),
    .hi_o     (bus.hi_o),
    .lo_o     (bus.lo_o)
  );
endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb/tb_alu_ctrl_mc.sv - directed self-checking bench for alu_ctrl_mc
module tb_alu_ctrl_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_mc_if #(.WIDTH(32)) bus32 ();
  alu_ctrl_mc_if #(.WIDTH(8))  bus8 ();

  alu_ctrl_mc #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  alu_ctrl_mc #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));

  // {ALUOp, funct, expected ALUCtrl}
  localparam logic [12:0] DEC [17] = '{
    {3'b010, 6'b100000, 4'b0010}, {3'b010, 6'b100010, 4'b0110},
    {3'b010, 6'b100100, 4'b0000}, {3'b010, 6'b100101, 4'b0001},
    {3'b010, 6'b101010, 4'b0111}, {3'b010, 6'b000000, 4'b0101},
    {3'b010, 6'b000110, 4'b1111}, {3'b010, 6'b011000, 4'b0011},
    {3'b010, 6'b011001, 4'b0011}, {3'b010, 6'b010000, 4'b1000},
    {3'b010, 6'b010010, 4'b1001}, {3'b110, 6'b111111, 4'b0010},
    {3'b011, 6'b111111, 4'b0111}, {3'b001, 6'b111111, 4'b0110},
    {3'b100, 6'b111111, 4'b0100}, {3'b111, 6'b111111, 4'b0001},
    {3'b101, 6'b111111, 4'b0011}
  };

  task automatic drive32(input logic v, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus32.valid_i = v;
    bus32.ALUOp_i = 3'b010;
    bus32.funct_i = fn;
    bus32.src1_i  = a;
    bus32.src2_i  = b;
  endtask

  task automatic test_reset;
    bus32.valid_i = 1'b0; bus32.ALUOp_i = 3'b000; bus32.funct_i = 6'd0;
    bus32.src1_i = 32'd0; bus32.src2_i = 32'd0;
    bus8.valid_i = 1'b0; bus8.ALUOp_i = 3'b000; bus8.funct_i = 6'd0;
    bus8.src1_i = 8'd0; bus8.src2_i = 8'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus32.busy_o !== 1'b0 || bus32.done_o !== 1'b0 || bus32.hi_o !== 32'd0 || bus32.lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0",
               bus32.busy_o, bus32.done_o, bus32.hi_o, bus32.lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode;
    logic [12:0] e;
    logic        v;
    for (int i = 0; i < 17; i++) begin
      e = DEC[i];
      v = !(e[12:10] == 3'b010 && (e[9:4] == 6'b011000 || e[9:4] == 6'b011001));
      @(negedge clk);
      bus32.valid_i = v; bus32.ALUOp_i = e[12:10]; bus32.funct_i = e[9:4];
      #1;
      checks++;
      if (bus32.ALUCtrl_o !== e[3:0] || bus32.illegal_o !== 1'b0 || bus32.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL decode[%0d] op=%b fn=%b: ctrl=%b illegal=%b busy=%b, want %b 0 0",
                 i, e[12:10], e[9:4], bus32.ALUCtrl_o, bus32.illegal_o, bus32.busy_o, e[3:0]);
      end
    end
    @(negedge clk);
    bus32.valid_i = 1'b1; bus32.ALUOp_i = 3'b010; bus32.funct_i = 6'b111111;
    #1;
    checks++;
    if (bus32.ALUCtrl_o !== 4'b0000 || bus32.illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_funct: ctrl=%b illegal=%b, want 0000 1", bus32.ALUCtrl_o, bus32.illegal_o);
    end
    bus32.ALUOp_i = 3'b000; bus32.funct_i = 6'b100000;
    #1;
    checks++;
    if (bus32.ALUCtrl_o !== 4'b0000 || bus32.illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: ctrl=%b illegal=%b, want 0000 1", bus32.ALUCtrl_o, bus32.illegal_o);
    end
    bus32.valid_i = 1'b0;
    #1;
    checks++;
    if (bus32.illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_novalid: illegal=%b, want 0", bus32.illegal_o);
    end
  endtask

  // Caller positions at a negedge (cycle 0). Returns at cycle 34 + 1 time unit.
  task automatic mult32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name,
                        input logic chain, input logic nsgn, input logic [31:0] na, input logic [31:0] nb);
    drive32(1'b1, sgn ? 6'b011000 : 6'b011001, a, b);
    #1;
    checks++;
    if (bus32.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_c0: busy=%b, want 1", name, bus32.busy_o);
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) bus32.valid_i = 1'b0;
      #1;
      checks++;
      if (bus32.busy_o !== 1'b1 || bus32.done_o !== 1'b0) begin
        errors++;
        $display("FAIL %s_cycle%0d: busy=%b done=%b, want 1 0", name, k, bus32.busy_o, bus32.done_o);
      end
    end
    @(negedge clk);
    if (chain) drive32(1'b1, nsgn ? 6'b011000 : 6'b011001, na, nb);
    #1;
    checks++;
    if (bus32.done_o !== 1'b1 || bus32.busy_o !== chain || bus32.hi_o !== ehi || bus32.lo_o !== elo) begin
      errors++;
      $display("FAIL %s_result: done=%b busy=%b hi=%h lo=%h, want 1 %b %h %h",
               name, bus32.done_o, bus32.busy_o, bus32.hi_o, bus32.lo_o, chain, ehi, elo);
    end
  endtask

  task automatic test_multu;
    @(negedge clk);
    mult32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    checks++;
    if (bus32.done_o !== 1'b0 || bus32.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b busy=%b, want 0 0", bus32.done_o, bus32.busy_o);
    end
  endtask

  task automatic test_mult_signed;
    @(negedge clk);
    mult32(1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7", 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    mult32(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin", 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_width8;
    @(negedge clk);
    bus8.valid_i = 1'b1; bus8.ALUOp_i = 3'b010; bus8.funct_i = 6'b011000;
    bus8.src1_i = 8'h80; bus8.src2_i = 8'hFF;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) bus8.valid_i = 1'b0;
      #1;
      checks++;
      if (k <= 9 && (bus8.busy_o !== 1'b1 || bus8.done_o !== 1'b0)) begin
        errors++;
        $display("FAIL w8_cycle%0d: busy=%b done=%b, want 1 0", k, bus8.busy_o, bus8.done_o);
      end else if (k == 10 && (bus8.done_o !== 1'b1 || bus8.busy_o !== 1'b0 ||
                               bus8.hi_o !== 8'h00 || bus8.lo_o !== 8'h80)) begin
        errors++;
        $display("FAIL w8_result: done=%b busy=%b hi=%h lo=%h, want 1 0 00 80",
                 bus8.done_o, bus8.busy_o, bus8.hi_o, bus8.lo_o);
      end
    end
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    drive32(1'b1, 6'b011000, 32'd5, 32'd9);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus32.valid_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus32.busy_o !== 1'b0 || bus32.hi_o !== 32'd0 || bus32.lo_o !== 32'd0 || bus32.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0",
               bus32.busy_o, bus32.done_o, bus32.hi_o, bus32.lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus32.done_o !== 1'b0 || bus32.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_cycle%0d: done=%b busy=%b, want 0 0", k, bus32.done_o, bus32.busy_o);
      end
    end
    @(negedge clk);
    mult32(1'b1, 32'd6, 32'd7, 32'd0, 32'd42, "mult_6x7", 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_interlock;
    @(negedge clk);
    drive32(1'b1, 6'b011000, 32'h80000000, 32'h80000000);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) bus32.valid_i = 1'b0;
      if (k == 3) drive32(1'b1, 6'b010000, 32'd0, 32'd0);
      if (k >= 4 && k <= 10) drive32(1'b1, 6'b011000, 32'd3, 32'd3);
      if (k == 11) bus32.valid_i = 1'b0;
      #1;
      checks++;
      if (k == 3 && (bus32.busy_o !== 1'b1 || bus32.ALUCtrl_o !== 4'b1000 || bus32.hi_o !== 32'd0)) begin
        errors++;
        $display("FAIL mfhi_stall: busy=%b ctrl=%b hi=%h, want 1 1000 0", bus32.busy_o, bus32.ALUCtrl_o, bus32.hi_o);
      end else if (k != 3 && k <= 33 && (bus32.busy_o !== 1'b1 || bus32.done_o !== 1'b0 || bus32.hi_o !== 32'd0)) begin
        errors++;
        $display("FAIL interlock_cycle%0d: busy=%b done=%b hi=%h, want 1 0 0", k, bus32.busy_o, bus32.done_o, bus32.hi_o);
      end else if (k == 34 && (bus32.done_o !== 1'b1 || bus32.hi_o !== 32'h40000000 || bus32.lo_o !== 32'd0)) begin
        errors++;
        $display("FAIL interlock_result: done=%b hi=%h lo=%h, want 1 40000000 0", bus32.done_o, bus32.hi_o, bus32.lo_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    mult32(1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "b2b_first", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    mult32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "b2b_second", 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_multu();
    test_mult_signed();
    test_width8();
    test_reset_midrun();
    test_interlock();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
